// File: rtl/multicycle_adder.sv
// ----------------------------------------------------------------------------
// multicycle_adder
//
// Adds two WIDTH-bit operands CHUNK bits per clock cycle. It supports
// ADD/ADC/SUB/SBC/RSB/RSC and produces ARM-style C, N, Z and V flags.
// Operands are captured when a start is accepted in IDLE. The result and
// flags become visible only when the last chunk completes.
//
// Ports:
//   in_Clk     - single clock, all state updates on the rising edge
//   in_nReset  - asynchronous active-low reset
//   in_Start   - begin an operation (sampled only in IDLE)
//   in_Mode    - 000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 RSB, 101 RSC,
//                110/111 behave as ADD
//   in_Rn      - first operand
//   in_Op2     - second operand
//   in_Carry   - carry flag input for ADC/SBC/RSC
//   in_Flush   - synchronous abort of an operation in CALC
//   out_Busy   - high whenever the block is not IDLE
//   out_Done   - one-cycle pulse, out_Y/out_CNZV just updated
//   out_Y      - result of the last completed operation
//   out_CNZV   - flags of the last completed operation {C, N, Z, V}
// ----------------------------------------------------------------------------
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             in_Clk,
    input  logic             in_nReset,
    input  logic             in_Start,
    input  logic [2:0]       in_Mode,
    input  logic [WIDTH-1:0] in_Rn,
    input  logic [WIDTH-1:0] in_Op2,
    input  logic             in_Carry,
    input  logic             in_Flush,
    output logic             out_Busy,
    output logic             out_Done,
    output logic [WIDTH-1:0] out_Y,
    output logic [3:0]       out_CNZV
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             a_msb;
    logic             b_msb;
    logic [CW-1:0]    chunk_cnt;

    logic             swap_ops;
    logic             invert_b;
    logic             carry_in;
    logic [WIDTH-1:0] prep_a;
    logic [WIDTH-1:0] prep_b;

    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] sum_next;
    logic             flag_z;
    logic             flag_v;

    // Decode the mode into operand preparation. Reverse subtracts swap
    // the operands. All subtracts add the inverted B plus a carry-in, so
    // the carry-out directly means "no borrow". Unused modes fall back to ADD.
    always_comb begin
        swap_ops = 1'b0;
        invert_b = 1'b0;
        carry_in = 1'b0;
        case (in_Mode)
            3'b001: begin
                carry_in = in_Carry;
            end
            3'b010: begin
                invert_b = 1'b1;
                carry_in = 1'b1;
            end
            3'b011: begin
                invert_b = 1'b1;
                carry_in = in_Carry;
            end
            3'b100: begin
                swap_ops = 1'b1;
                invert_b = 1'b1;
                carry_in = 1'b1;
            end
            3'b101: begin
                swap_ops = 1'b1;
                invert_b = 1'b1;
                carry_in = in_Carry;
            end
            default: begin
                carry_in = 1'b0;
            end
        endcase
        prep_a = swap_ops ? in_Op2 : in_Rn;
        prep_b = swap_ops ? in_Rn : in_Op2;
        if (invert_b) begin
            prep_b = ~prep_b;
        end
    end

    // The operand registers shift right one chunk per cycle, so the
    // active chunk is always in the low bits. Each new result chunk enters
    // at the top of the result register. After NCHUNK cycles the register
    // holds exactly the full result. The flags are taken from the value
    // the register will hold after this cycle. The MSBs of the prepared
    // operands are kept separately because the shifting discards them.
    always_comb begin
        chunk_sum = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_reg};
        sum_next  = (sum_reg >> CHUNK)
                  | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        flag_z    = (sum_next == '0);
        flag_v    = (a_msb == b_msb) && (sum_next[WIDTH-1] != a_msb);
    end

    // Control FSM and all registered outputs. Only the final chunk of a
    // completed operation writes out_Y/out_CNZV. A flush or a reset
    // therefore leaves the visible result untouched or cleared, and never
    // shows a partial sum.
    always_ff @(posedge in_Clk or negedge in_nReset) begin
        if (!in_nReset) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            chunk_cnt <= '0;
            out_Busy  <= 1'b0;
            out_Done  <= 1'b0;
            out_Y     <= '0;
            out_CNZV  <= 4'b0000;
        end else begin
            out_Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_Start) begin
                        a_reg     <= prep_a;
                        b_reg     <= prep_b;
                        a_msb     <= prep_a[WIDTH-1];
                        b_msb     <= prep_b[WIDTH-1];
                        carry_reg <= carry_in;
                        chunk_cnt <= '0;
                        out_Busy  <= 1'b1;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    if (in_Flush) begin
                        out_Busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        a_reg     <= a_reg >> CHUNK;
                        b_reg     <= b_reg >> CHUNK;
                        sum_reg   <= sum_next;
                        carry_reg <= chunk_sum[CHUNK];
                        chunk_cnt <= chunk_cnt + 1'b1;
                        if (chunk_cnt == LAST_CHUNK) begin
                            out_Y    <= sum_next;
                            out_CNZV <= {chunk_sum[CHUNK], sum_next[WIDTH-1],
                                         flag_z, flag_v};
                            out_Done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    out_Busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    out_Busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// ----------------------------------------------------------------------------
// tb_multicycle_adder
//
// Testbench for multicycle_adder. The main instance uses WIDTH=32 and
// CHUNK=8, and a scoreboard checks it. Whenever the stimulus issues an
// operation that should complete, it pushes the result, flags and due cycle
// from a behavioural reference model. A monitor pops one entry per out_Done
// pulse. Two more instances (16/4 and 32/32) check the carry-wrap case and
// its latency.
// ----------------------------------------------------------------------------
module tb_multicycle_adder;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  cnzv;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mode = 3'b000;
    logic [31:0] rn = '0;
    logic [31:0] op2 = '0;
    logic        carry = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] y;
    logic [3:0]  cnzv;

    logic        start16 = 1'b0;
    logic [15:0] rn16 = '0;
    logic [15:0] op16 = '0;
    logic        busy16;
    logic        done16;
    logic [15:0] y16;
    logic [3:0]  cnzv16;

    logic        start1 = 1'b0;
    logic [31:0] rn1 = '0;
    logic [31:0] op1 = '0;
    logic        busy1;
    logic        done1;
    logic [31:0] y1;
    logic [3:0]  cnzv1;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] last_y = '0;
    logic [3:0]  last_cnzv = '0;

    multicycle_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .in_Clk(clk), .in_nReset(rst_n), .in_Start(start), .in_Mode(mode),
        .in_Rn(rn), .in_Op2(op2), .in_Carry(carry), .in_Flush(flush),
        .out_Busy(busy), .out_Done(done), .out_Y(y), .out_CNZV(cnzv)
    );

    multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .in_Clk(clk), .in_nReset(rst_n), .in_Start(start16), .in_Mode(3'b000),
        .in_Rn(rn16), .in_Op2(op16), .in_Carry(1'b0), .in_Flush(1'b0),
        .out_Busy(busy16), .out_Done(done16), .out_Y(y16), .out_CNZV(cnzv16)
    );

    multicycle_adder #(.WIDTH(32), .CHUNK(32)) dut1 (
        .in_Clk(clk), .in_nReset(rst_n), .in_Start(start1), .in_Mode(3'b000),
        .in_Rn(rn1), .in_Op2(op1), .in_Carry(1'b0), .in_Flush(1'b0),
        .out_Busy(busy1), .out_Done(done1), .out_Y(y1), .out_CNZV(cnzv1)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter for latency checks. It advances on every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Reference model with plain arithmetic. Additions give C when the
    // unsigned sum overflows. Subtractions give C when no borrow occurs.
    // V is set when the signed result does not fit in 32 bits.
    function automatic logic [35:0] refModel(input logic [2:0] m,
                                             input logic [31:0] rn_v,
                                             input logic [31:0] op_v,
                                             input logic c_in);
        logic [31:0] x;
        logic [31:0] z;
        logic [31:0] res;
        longint      ux;
        longint      uz;
        longint      sx;
        longint      sz;
        longint      u;
        longint      s;
        longint      cin;
        bit          is_sub;
        logic        c_out;
        logic        v;
        x = rn_v;
        z = op_v;
        is_sub = 1'b0;
        cin = 0;
        case (m)
            3'd1: cin = longint'(c_in);
            3'd2: begin is_sub = 1'b1; cin = 1; end
            3'd3: begin is_sub = 1'b1; cin = longint'(c_in); end
            3'd4: begin is_sub = 1'b1; cin = 1; x = op_v; z = rn_v; end
            3'd5: begin is_sub = 1'b1; cin = longint'(c_in); x = op_v; z = rn_v; end
            default: cin = 0;
        endcase
        ux = longint'({32'd0, x});
        uz = longint'({32'd0, z});
        sx = longint'($signed(x));
        sz = longint'($signed(z));
        if (is_sub) begin
            u = ux - uz - (1 - cin);
            s = sx - sz - (1 - cin);
            c_out = (u >= 0);
        end else begin
            u = ux + uz + cin;
            s = sx + sz + cin;
            c_out = ((u >>> 32) != 0);
        end
        res = u[31:0];
        v = (s != longint'($signed(res)));
        return {res, c_out, res[31], (res == 32'd0), v};
    endfunction

    // Counts one comparison and reports it if it fails.
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor. Every out_Done pulse must match the oldest
    // outstanding expectation in value and in arrival cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    checkOutput("result_y", 64'(y), 64'(e.y));
                    checkOutput("flags_cnzv", 64'(cnzv), 64'(e.cnzv));
                    checkOutput("done_cycle", 64'(cyc), 64'(e.due));
                    last_y = e.y;
                    last_cnzv = e.cnzv;
                end
            end
        end
    end

    // Issue one start pulse. If the operation should complete, push its
    // expected outcome. After the capture edge, scramble the operand
    // inputs so that a design that fails to capture them is exposed.
    task automatic applyStimulus(input logic [2:0] m, input logic [31:0] a,
                                 input logic [31:0] b, input logic c,
                                 input bit expect_done);
        logic [35:0] r;
        exp_t        e;
        @(negedge clk);
        start = 1'b1;
        mode = m;
        rn = a;
        op2 = b;
        carry = c;
        if (expect_done) begin
            r = refModel(m, a, b, c);
            e.y = r[35:4];
            e.cnzv = r[3:0];
            e.due = cyc + 1 + NCHUNK;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        rn = $urandom;
        op2 = $urandom;
        mode = 3'($urandom_range(0, 7));
        carry = 1'($urandom_range(0, 1));
        checkOutput("busy_after_start", 64'(busy), 64'd1);
    endtask

    // Wait, with a bound, until every outstanding expectation is consumed.
    task automatic waitIdle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 4 * NCHUNK + 10) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout: got no done expected %0d pending", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int t0;
        int n;

        // Reset state, then release on a falling edge.
        repeat (2) @(negedge clk);
        checkOutput("reset_y", 64'(y), 64'd0);
        checkOutput("reset_cnzv", 64'(cnzv), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        rst_n = 1'b1;

        // Directed corner cases. The first start directly follows reset.
        applyStimulus(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        waitIdle();
        applyStimulus(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        waitIdle();
        applyStimulus(3'b010, 32'd5, 32'd5, 1'b0, 1'b1);
        waitIdle();
        applyStimulus(3'b010, 32'd0, 32'd1, 1'b0, 1'b1);
        waitIdle();
        applyStimulus(3'b100, 32'd1, 32'd0, 1'b0, 1'b1);
        waitIdle();
        applyStimulus(3'b011, 32'd0, 32'd0, 1'b0, 1'b1);
        waitIdle();
        checkOutput("hold_y", 64'(y), 64'hFFFF_FFFF);
        checkOutput("hold_cnzv", 64'(cnzv), 64'b0100);

        // A second start with other operands during CALC is ignored.
        applyStimulus(3'b001, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1);
        start = 1'b1;
        mode = 3'b010;
        rn = 32'hDEAD_BEEF;
        op2 = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0;
        waitIdle();

        // A start that arrives while in DONE is dropped.
        applyStimulus(3'b101, 32'h0000_0010, 32'h0000_0100, 1'b0, 1'b1);
        repeat (NCHUNK) @(negedge clk);
        start = 1'b1;
        rn = 32'h1111_1111;
        op2 = 32'h2222_2222;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_in_done_ignored", 64'(busy), 64'd0);
        waitIdle();

        // A flush in the second CALC cycle aborts and keeps the old result.
        applyStimulus(3'b000, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", 64'(busy), 64'd0);
        repeat (2 * NCHUNK) @(negedge clk);
        checkOutput("flush_hold_y", 64'(y), 64'(last_y));
        checkOutput("flush_hold_cnzv", 64'(cnzv), 64'(last_cnzv));

        // If flush and start coincide in IDLE, the start wins.
        flush = 1'b1;
        applyStimulus(3'b110, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        waitIdle();

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand(),
                          1'($urandom_range(0, 1)), 1'b1);
            waitIdle();
        end

        // A reset in mid-operation clears the outputs at once. No out_Done
        // follows the release.
        applyStimulus(3'b000, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_y", 64'(y), 64'd0);
        checkOutput("async_reset_cnzv", 64'(cnzv), 64'd0);
        checkOutput("async_reset_busy", 64'(busy), 64'd0);
        checkOutput("async_reset_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_y = '0;
        last_cnzv = '0;
        repeat (2 * NCHUNK) @(negedge clk);
        checkOutput("post_reset_busy", 64'(busy), 64'd0);
        applyStimulus(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        waitIdle();

        // WIDTH=16, CHUNK=4: the same wrap case takes four cycles.
        @(negedge clk);
        start16 = 1'b1;
        rn16 = 16'hFFFF;
        op16 = 16'h0001;
        t0 = cyc;
        @(negedge clk);
        start16 = 1'b0;
        n = 0;
        while (done16 !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        checkOutput("w16_latency", 64'(cyc - t0 - 1), 64'd4);
        checkOutput("w16_y", 64'(y16), 64'd0);
        checkOutput("w16_cnzv", 64'(cnzv16), 64'b1010);

        // WIDTH=32, CHUNK=32: the result arrives after one cycle.
        @(negedge clk);
        start1 = 1'b1;
        rn1 = 32'hFFFF_FFFF;
        op1 = 32'h0000_0001;
        t0 = cyc;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (done1 !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        checkOutput("w32c32_latency", 64'(cyc - t0 - 1), 64'd1);
        checkOutput("w32c32_y", 64'(y1), 64'd0);
        checkOutput("w32c32_cnzv", 64'(cnzv1), 64'b1010);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits.
REQ-002 Parameter CHUNK, default 8: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 in_Clk  input  1  single clock; all state updates on rising edge.
REQ-004 in_nReset  input  1  asynchronous, active-low reset.
REQ-005 in_Start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 in_Mode  input  3  operation: 000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 RSB, 101 RSC, 110/111 treated as ADD.
REQ-007 in_Rn  input  WIDTH  first operand.
REQ-008 in_Op2  input  WIDTH  second operand.
REQ-009 in_Carry  input  1  carry flag input, used by ADC/SBC/RSC.
REQ-010 in_Flush  input  1  synchronous abort of an operation in progress.
REQ-011 out_Busy  output  1  high whenever state is not IDLE.
REQ-012 out_Done  output  1  one-cycle pulse: result and flags valid.
REQ-013 out_Y  output  WIDTH  result.
REQ-014 out_CNZV  output  4  flags: [3]=C, [2]=N, [1]=Z, [0]=V.

Function
REQ-015 The block SHALL implement states IDLE, CALC, DONE.
REQ-016 IDLE with in_Start=1 at an edge SHALL capture in_Rn, in_Op2, in_Mode and in_Carry into internal registers, clear the chunk counter to 0, and enter CALC.
REQ-017 Operand preparation at capture: A=in_Rn, B=in_Op2 for ADD/ADC/SUB/SBC; A=in_Op2, B=in_Rn for RSB/RSC; B inverted for SUB/SBC/RSB/RSC.
REQ-018 Carry-in: 0 for ADD, 1 for SUB/RSB, in_Carry for ADC/SBC/RSC.
REQ-019 Each CALC cycle SHALL add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) of A and B plus the running carry, write that chunk of the result register, update the running carry and increment k.
REQ-020 After chunk NCHUNK-1 is processed the block SHALL enter DONE; latency from the capturing edge to out_Done high is exactly NCHUNK cycles.
REQ-021 In DONE: out_Done=1 for exactly one cycle, then unconditional return to IDLE; in_Start in DONE SHALL be ignored.
REQ-022 Flags at DONE: C = final carry-out (ARM convention, C=1 means no borrow); N = result MSB; Z = 1 iff result is all zeros; V = 1 iff A[MSB]==B[MSB] (after preparation) and result MSB != A[MSB].
REQ-023 out_Y and out_CNZV SHALL update only on entry to DONE and hold until the next completed operation; partial results SHALL never appear on out_Y.
REQ-024 in_Start while Busy SHALL be ignored; no queueing.
REQ-025 in_Flush=1 in CALC SHALL return to IDLE at the next edge without pulsing out_Done and without changing out_Y/out_CNZV; in_Flush in IDLE or DONE has no effect; in_Flush with in_Start in IDLE: start wins.
REQ-026 Operand inputs SHALL be don't-care except at the capturing edge.

Reset
REQ-027 in_nReset low SHALL immediately force state IDLE, counter 0, out_Busy=0, out_Done=0, out_Y=0, out_CNZV=4'b0000, regardless of clock.
REQ-028 Reset asserted mid-operation SHALL discard the operation; no out_Done follows release.
REQ-029 First in_Start is accepted at the first rising edge after in_nReset deasserts.

Verification (WIDTH=32, CHUNK=8)
REQ-030 ADD 0xFFFFFFFF + 0x00000001 -> out_Done 4 cycles after start, out_Y=0x00000000, CNZV=1010.
REQ-031 ADD 0x7FFFFFFF + 0x00000001 -> out_Y=0x80000000, CNZV=0101; SUB 5-5 -> out_Y=0, CNZV=1010.
REQ-032 SUB 0-1 -> out_Y=0xFFFFFFFF, CNZV=0100; RSB in_Rn=1, in_Op2=0 -> identical result; SBC 0-0 with in_Carry=0 -> 0xFFFFFFFF, CNZV=0100.
REQ-033 Second in_Start during CALC with different operands -> ignored, first result delivered unchanged, single out_Done pulse.
REQ-034 in_Flush in cycle 2 of CALC -> IDLE next cycle, no out_Done, out_Y/out_CNZV retain prior values; new start then completes normally.
REQ-035 in_nReset asserted in CALC -> out_* zero immediately, no out_Done after release; repeat REQ-030 with WIDTH=16, CHUNK=4 and WIDTH=32, CHUNK=32 (latency 1).
